// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM state
// encoding, register offsets, CTRL field positions and MODE encodings.
package mmio_timer_pkg;

  // Timer FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } timer_state_e;

  // Word offsets within the device window (byte address bits [3:2])
  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;

  // CTRL bit positions
  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlImBit   = 3;

  // MODE encodings; the two 1x codes behave like one-shot
  localparam logic [1:0] ModeOneShot    = 2'b00;
  localparam logic [1:0] ModeAutoReload = 2'b01;

  // Decoded CTRL register
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // Unpack the low CTRL bits of a store into the decoded register
  function automatic ctrl_t word_to_ctrl(input logic [3:0] w);
    ctrl_t c;
    c.en   = w[CtrlEnBit];
    c.mode = w[CtrlModeLsb +: 2];
    c.im   = w[CtrlImBit];
    return c;
  endfunction

  // Pack the decoded register into its bus view; bits [31:4] read 0
  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] w;
    w                     = '0;
    w[CtrlEnBit]          = c.en;
    w[CtrlModeLsb +: 2]   = c.mode;
    w[CtrlImBit]          = c.im;
    return w;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit countdown timer with one-shot and auto-reload modes
// and a maskable interrupt. Register reads are combinational.
module mmio_timer
  import mmio_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  timer_state_e state_q;
  ctrl_t        ctrl_q;
  logic [31:0]  preset_q;
  logic [31:0]  count_q;
  logic         irq_flag_q;

  logic ctrl_wr;
  logic preset_wr;

  // Store decode; COUNT and the reserved word silently drop writes
  always_comb begin
    ctrl_wr   = we && (addr == AddrCtrl);
    preset_wr = we && (addr == AddrPreset);
  end

  // Timer FSM and CPU-visible registers. CPU writes are applied after the
  // FSM updates so they override FSM-driven changes in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ctrl_q.en) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          // PRESET is sampled only here, so mid-count PRESET writes wait
          count_q <= preset_q;
          state_q <= StCnt;
        end
        StCnt: begin
          if (!ctrl_q.en) begin
            state_q <= StIdle;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            // Covers COUNT==0 after a zero PRESET: no wrap below zero
            count_q    <= '0;
            irq_flag_q <= 1'b1;
            state_q    <= StInt;
          end
        end
        StInt: begin
          case (ctrl_q.mode)
            ModeAutoReload: begin
              // Flag lives exactly one cycle per period in this mode
              irq_flag_q <= 1'b0;
              state_q    <= StLoad;
            end
            ModeOneShot: begin
              ctrl_q.en <= 1'b0;
              state_q   <= StIdle;
            end
            default: begin
              ctrl_q.en <= 1'b0;
              state_q   <= StIdle;
            end
          endcase
        end
        default: state_q <= StIdle;
      endcase

      if (ctrl_wr) begin
        ctrl_q     <= word_to_ctrl(wdata[3:0]);
        irq_flag_q <= 1'b0;
      end
      if (preset_wr) begin
        preset_q <= wdata;
      end
    end
  end

  // Zero-latency register read mux
  always_comb begin
    rdata = '0;
    case (addr)
      AddrCtrl:   rdata = ctrl_to_word(ctrl_q);
      AddrPreset: rdata = preset_q;
      AddrCount:  rdata = count_q;
      default:    rdata = '0;
    endcase
  end

  // Interrupt output gated by the mask bit
  always_comb begin
    irq = ctrl_q.im & irq_flag_q;
  end

  // The flag can only be pending while parked in INT or IDLE
  a_flag_state : assert property (@(posedge clk) disable iff (!reset)
    irq_flag_q |-> (state_q == StIdle || state_q == StInt));

  // LOAD is a single-cycle state
  a_load_once : assert property (@(posedge clk) disable iff (!reset)
    (state_q == StLoad) |=> (state_q == StCnt));

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: scoreboard queues hold expected values
// pushed as stimulus is driven and popped when the DUT output is sampled.
module tb_mmio_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  string       sb_name[$];
  logic [31:0] sb_val[$];

  mmio_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string name, input logic [31:0] val);
    sb_name.push_back(name);
    sb_val.push_back(val);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    we    = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] obs, ev;
    string en;
    reset = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;
    #2;
    for (int a = 0; a < 4; a++) begin
      push_exp($sformatf("reset_rdata_%0d", a), 32'd0);
      rd(2'(a), obs);
      en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
      end
    end
    push_exp("reset_irq", 32'd0);
    obs = {31'b0, irq};
    en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== ev) begin
      n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_one_shot();
    logic [31:0] obs, ev;
    string en;
    do_reset();
    cpu_write(2'd1, 32'd5);
    cpu_write(2'd0, 32'h9);   // edge 0
    tick(); tick();           // edge 2
    push_exp("oneshot_count_e2", 32'd5);
    rd(2'd2, obs);
    en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== ev) begin
      n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
    end
    for (int e = 3; e <= 12; e++) begin
      push_exp($sformatf("oneshot_irq_e%0d", e), (e >= 7) ? 32'd1 : 32'd0);
      tick();
      obs = {31'b0, irq};
      en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
      end
    end
    push_exp("oneshot_ctrl_after", 32'h8);
    rd(2'd0, obs);
    en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== ev) begin
      n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
    end
    cpu_write(2'd0, 32'h8);
    push_exp("oneshot_irq_cleared", 32'd0);
    obs = {31'b0, irq};
    en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== ev) begin
      n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
    end
  endtask

  task automatic test_auto_reload();
    logic [31:0] obs, ev;
    string en;
    int pulses;
    pulses = 0;
    do_reset();
    cpu_write(2'd1, 32'd3);
    cpu_write(2'd0, 32'hB);   // edge 0
    for (int e = 1; e <= 21; e++) begin
      push_exp($sformatf("reload_irq_e%0d", e), (e % 5 == 0) ? 32'd1 : 32'd0);
      tick();
      obs = {31'b0, irq};
      if (irq === 1'b1) pulses++;
      en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
      end
    end
    push_exp("reload_pulse_count", 32'd4);
    obs = 32'(pulses);
    en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== ev) begin
      n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
    end
    cpu_write(2'd0, 32'h0);
  endtask

  task automatic test_mask();
    logic [31:0] obs, ev;
    string en;
    do_reset();
    cpu_write(2'd1, 32'd2);
    cpu_write(2'd0, 32'h1);
    for (int e = 1; e <= 8; e++) begin
      push_exp($sformatf("mask_irq_e%0d", e), 32'd0);
      tick();
      obs = {31'b0, irq};
      en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
      end
    end
    push_exp("mask_count", 32'd0);
    push_exp("mask_ctrl", 32'd0);
    for (int a = 2; a >= 0; a -= 2) begin
      rd(2'(a), obs);
      en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] obs, ev;
    string en;
    do_reset();
    cpu_write(2'd1, 32'd10);
    cpu_write(2'd0, 32'h9);   // edge 0
    repeat (8) tick();        // edge 8: COUNT = 4
    push_exp("abort_count_e8", 32'd4);
    rd(2'd2, obs);
    en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== ev) begin
      n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
    end
    cpu_write(2'd0, 32'h8);   // edge 9: COUNT -> 3, EN drops
    for (int i = 0; i < 10; i++) begin
      push_exp($sformatf("abort_count_%0d", i), 32'd3);
      push_exp($sformatf("abort_irq_%0d", i), 32'd0);
      rd(2'd2, obs);
      en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
      end
      obs = {31'b0, irq};
      en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
      end
      tick();
    end
  endtask

  task automatic test_preset_zero();
    logic [31:0] obs, ev;
    string en;
    do_reset();
    cpu_write(2'd1, 32'd0);
    cpu_write(2'd0, 32'h9);   // edge 0
    for (int e = 1; e <= 4; e++) begin
      push_exp($sformatf("p0_irq_e%0d", e), (e >= 3) ? 32'd1 : 32'd0);
      tick();
      obs = {31'b0, irq};
      en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
      end
    end
    push_exp("p0_count", 32'd0);
    rd(2'd2, obs);
    en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== ev) begin
      n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
    end
  endtask

  task automatic test_regs();
    logic [31:0] obs, ev;
    string en;
    do_reset();
    cpu_write(2'd1, 32'd6);
    cpu_write(2'd0, 32'h1);        // edge 0
    tick(); tick();                // edge 2: COUNT = 6
    cpu_write(2'd2, 32'h1234);     // edge 3: ignored, COUNT = 5
    push_exp("regs_count_write_ignored", 32'd5);
    rd(2'd2, obs);
    en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== ev) begin
      n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
    end
    cpu_write(2'd1, 32'd100);      // edge 4: COUNT = 4, unaffected
    push_exp("regs_count_after_preset_wr", 32'd4);
    push_exp("regs_preset", 32'd100);
    for (int a = 2; a >= 1; a--) begin
      rd(2'(a), obs);
      en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
      end
    end
    // Read while a write to the same register is pending returns old data
    @(negedge clk);
    addr  = 2'd1;
    wdata = 32'hDEAD_BEEF;
    we    = 1'b1;
    push_exp("regs_read_during_write", 32'd100);
    #1;
    obs = rdata;
    en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== ev) begin
      n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    cpu_write(2'd3, 32'hFFFF_FFFF);
    push_exp("regs_preset_new", 32'hDEAD_BEEF);
    push_exp("regs_ctrl", 32'h1);
    push_exp("regs_rsvd", 32'd0);
    for (int i = 0; i < 3; i++) begin
      rd((i == 0) ? 2'd1 : (i == 1) ? 2'd0 : 2'd3, obs);
      en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] obs, ev;
    string en;
    do_reset();
    cpu_write(2'd1, 32'd20);
    cpu_write(2'd0, 32'h9);   // edge 0
    repeat (15) tick();       // edge 15: COUNT = 7
    push_exp("rmid_count_before", 32'd7);
    rd(2'd2, obs);
    en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== ev) begin
      n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
    end
    reset = 1'b0;             // asynchronous, between edges
    for (int a = 0; a < 4; a++) begin
      push_exp($sformatf("rmid_rdata_%0d", a), 32'd0);
      rd(2'(a), obs);
      en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
      end
    end
    push_exp("rmid_irq_in_reset", 32'd0);
    obs = {31'b0, irq};
    en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
    if (obs !== ev) begin
      n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_exp($sformatf("rmid_irq_after_%0d", i), 32'd0);
      tick();
      obs = {31'b0, irq};
      en = sb_name.pop_front(); ev = sb_val.pop_front(); n_checks++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL %s: observed 0x%08h, expected 0x%08h", en, obs, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_mask();
    test_abort();
    test_preset_zero();
    test_regs();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  rising-edge system clock, shared with the CPU pipeline.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 addr  input  2  word offset from the CPU data bus (byte address bits [3:2]).
REQ-005 we  input  1  CPU store strobe, already qualified by the bus decoder for this device.
REQ-006 wdata  input  32  CPU store data; full-word writes only.
REQ-007 rdata  output  32  combinational read data for the current addr.
REQ-008 irq  output  1  interrupt request to the CPU.

Function
REQ-009 Register map:
- addr 0 = CTRL, read/write: bit3 IM (irq mask), bits[2:1] MODE, bit0 EN; bits[31:4] read 0.
- addr 1 = PRESET, read/write, 32-bit.
- addr 2 = COUNT, read-only.
- addr 3 reads 0.
REQ-010 Writes take effect at the clk edge where we=1; writes to addr 2 or addr 3 SHALL be ignored.
REQ-011 rdata SHALL reflect register contents with zero-cycle latency; a read in the same cycle as a write returns the old value.
REQ-012 FSM states: IDLE, LOAD, CNT, INT.
REQ-013 IDLE: EN=1 -> LOAD; otherwise stay, COUNT held.
REQ-014 LOAD: COUNT<=PRESET; -> CNT.
REQ-015 CNT:
- EN=0 -> IDLE, COUNT frozen.
- else COUNT>1 -> COUNT-1, stay in CNT.
- else (COUNT<=1) -> COUNT<=0, set irq_flag, -> INT.
REQ-016 INT:
- MODE=00 (one-shot): EN<=0, irq_flag held, -> IDLE.
- MODE=01 (auto-reload): irq_flag<=0, -> LOAD; irq_flag is therefore a one-cycle pulse.
- MODE=1x: treated as 00.
REQ-017 irq SHALL equal IM AND irq_flag (combinational).
REQ-018 Any CTRL write SHALL clear irq_flag.
REQ-019 A CPU CTRL write and an FSM EN clear in the same cycle: the CPU write wins.
REQ-020 A PRESET write during CNT SHALL NOT alter COUNT until the next LOAD.
REQ-021 PRESET=0: LOAD yields COUNT=0, then INT on the next edge; no decrement underflow past 0.
REQ-022 Latency: EN set at edge k with PRESET=P>=1 -> irq_flag set at edge k+P+2.

Reset
REQ-023 reset=0 SHALL immediately clear CTRL, PRESET, COUNT and irq_flag, and force state IDLE.
REQ-024 Outputs during reset: irq=0; rdata=0 for all addr.
REQ-025 Reset asserted mid-count aborts the count; no irq is issued after release until software re-enables the timer.

Structure
REQ-026 Shared package mmio_timer_pkg SHALL hold:
- FSM state encoding;
- register offsets (CTRL=0, PRESET=1, COUNT=2);
- CTRL bit positions and MODE encodings.
REQ-027 Single module with no sub-module; the bus decoder selecting this device lives outside the block.

Verification
REQ-028 One-shot: PRESET=5, CTRL=0x9 at edge 0 -> COUNT=5 after edge 2, irq=1 after edge 7, CTRL reads 0x8, irq stays 1 until a CTRL write.
REQ-029 Auto-reload: PRESET=3, CTRL=0xB -> irq pulses high for exactly 1 cycle, every 5 cycles, for 4 periods.
REQ-030 Mask: PRESET=2, CTRL=0x1 -> irq never asserts; COUNT reaches 0; EN cleared.
REQ-031 Abort/edge cases:
- EN cleared at COUNT=3 -> COUNT frozen at 3, no irq.
- PRESET=0 -> irq 3 edges after the enable write.
- Write to COUNT ignored.
REQ-032 Reset: reset pulled low mid-count (COUNT=7) -> all registers read 0, irq=0 asynchronously; after release, no irq within 20 cycles.
